// File: rtl/addsub_accumulator_if.sv
// addsub_accumulator_if: operand/result bundle between operand generation and the accumulator
//   A, mode, in_valid, clear  : driven by the master (operand source)
//   in_ready                  : accumulator can take an operand
//   acc, Cout, ovf, op_count  : registered running total, carry/no-borrow, sticky overflow, op count
//   out_valid                 : pulse marking an acc/Cout update
interface addsub_accumulator_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
);
    logic [WIDTH-1:0] A;
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic             clear;
    logic [WIDTH-1:0] acc;
    logic             Cout;
    logic             ovf;
    logic [CNT_W-1:0] op_count;
    logic             out_valid;
    modport master (
        output A, mode, in_valid, clear,
        input  in_ready, acc, Cout, ovf, op_count, out_valid
    );
    modport slave (
        input  A, mode, in_valid, clear,
        output in_ready, acc, Cout, ovf, op_count, out_valid
    );
endinterface

// File: rtl/addsub_accumulator.sv
// addsub_accumulator: clocked add/sub accumulator with valid/ready handshake and capacity stop
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of addsub_accumulator_if (operand in, running total and flags out)
module addsub_accumulator #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input logic                  clk,
    input logic                  rst,
    addsub_accumulator_if.slave  bus
);
    typedef enum logic {RUN, FULL} state_t;
    // count value whose accept fills the counter to all-ones
    localparam logic [CNT_W-1:0] LAST = {{(CNT_W-1){1'b1}}, 1'b0};
    state_t           state, state_nxt;
    logic             accept;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;
    logic             ovf_op;
    assign bus.in_ready = state == RUN;
    assign accept       = bus.in_valid & bus.in_ready & ~bus.clear;
    // subtraction is acc + ~A + 1, so Cout doubles as the no-borrow flag
    always_comb begin
        b      = bus.mode ? ~bus.A : bus.A;
        sum    = {1'b0, bus.acc} + {1'b0, b} + (WIDTH+1)'(bus.mode);
        ovf_op = (bus.mode ? bus.acc[WIDTH-1] != bus.A[WIDTH-1] : bus.acc[WIDTH-1] == bus.A[WIDTH-1])
                 && sum[WIDTH-1] != bus.acc[WIDTH-1];
    end
    always_comb begin
        state_nxt = state;
        if (bus.clear)
            state_nxt = RUN;
        else if (accept && bus.op_count == LAST)
            state_nxt = FULL;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            bus.acc       <= '0;
            bus.Cout      <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.op_count  <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            state         <= state_nxt;
            bus.out_valid <= accept;
            if (bus.clear) begin
                bus.acc      <= '0;
                bus.Cout     <= 1'b0;
                bus.ovf      <= 1'b0;
                bus.op_count <= '0;
            end else if (accept) begin
                bus.acc      <= sum[WIDTH-1:0];
                bus.Cout     <= sum[WIDTH];
                bus.ovf      <= bus.ovf | ovf_op;
                bus.op_count <= bus.op_count + CNT_W'(1);
            end
        end
    end
endmodule
